// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: widths, port indices and
// the command word a requester presents.
package ram_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 12;

    // Port indices into the two-bit request/grant vectors.
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // One RAM access as presented by a requester.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Two-way grant selection for the RAM arbiter.
// Fixed priority (CPU port wins) by default; with RAM_ARBITER_ROUND_ROBIN_EN
// defined, contention is resolved in favour of the port not granted last.
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    input  logic       last,
`endif
    output logic [1:0] gnt
);

    // At most one grant; an uncontested request always wins.
    always_comb begin
        gnt = 2'b00;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        if (req[PORT_CPU] && req[PORT_LOADER]) begin
            if (last == PORT_LOADER) gnt[PORT_CPU]    = 1'b1;
            else                     gnt[PORT_LOADER] = 1'b1;
        end else if (req[PORT_CPU]) begin
            gnt[PORT_CPU] = 1'b1;
        end else if (req[PORT_LOADER]) begin
            gnt[PORT_LOADER] = 1'b1;
        end
`else
        if (req[PORT_CPU])         gnt[PORT_CPU]    = 1'b1;
        else if (req[PORT_LOADER]) gnt[PORT_LOADER] = 1'b1;
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the single-port program/data RAM.
// Grant in cycle N registers the command for N+1; read data from the RAM's
// combinational path is captured at the end of N+1 and flagged valid in N+2.
// Optional feature macro: RAM_ARBITER_ROUND_ROBIN_EN (round-robin on contention).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_pend;
    logic              rd_owner;

    // Requests seen while in reset are masked so no grant is issued.
    assign req = {m1_req & ~rst, m0_req & ~rst};

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic rr_last;

    ram_arbiter_pick u_pick (
        .req  (req),
        .last (rr_last),
        .gnt  (gnt)
    );

    // Remember which port took the most recent grant.
    always_ff @(posedge clk) begin
        if (rst)         rr_last <= PORT_LOADER;
        else if (|gnt)   rr_last <= gnt[PORT_LOADER];
    end
`else
    ram_arbiter_pick u_pick (
        .req (req),
        .gnt (gnt)
    );
`endif

    assign m0_gnt = gnt[PORT_CPU];
    assign m1_gnt = gnt[PORT_LOADER];

    // Command of the granted port.
    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (gnt[PORT_LOADER]) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // RAM command register; address/data hold through idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else if (|gnt) begin
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            ram_we   <= sel_we;
            rd_pend  <= ~sel_we;
            rd_owner <= gnt[PORT_LOADER];
        end else begin
            ram_we   <= 1'b0;
            rd_pend  <= 1'b0;
        end
    end

    // Return read data to the owning port one cycle after the RAM access.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= rd_pend && (rd_owner == PORT_CPU);
            m1_rvalid <= rd_pend && (rd_owner == PORT_LOADER);
            if (rd_pend && (rd_owner == PORT_CPU))    m0_rdata <= ram_dout;
            if (rd_pend && (rd_owner == PORT_LOADER)) m1_rdata <= ram_dout;
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single-port 256x12 program/data RAM.
- Port 0 is the CPU fetch/execute path; port 1 is the program loader/debug path.
- Serialises accesses, registers the RAM command, and returns read data to the owning requester with a fixed latency.
- Sits between the CPU core/loader and the RAM instance; the RAM's combinational read path feeds `ram_dout` back.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 12, RAM word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  port 0 access request, level, held until granted.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 request accepted this cycle (pulse).
- m0_rvalid  out  1  port 0 read data valid (pulse).
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the port 0 signals, for port 1.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_din  out  DATA_W  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_dout  in  DATA_W  RAM read data, combinational from ram_addr.

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous, active-high.
- Reset values: all gnt=0, rvalid=0, rdata=0; ram_addr=0, ram_din=0, ram_we=0; internal read-owner tag cleared; RR pointer = 1.
- Requester rules:
  - A requester raises req with we/addr/wdata stable and holds them until it samples gnt=1.
  - gnt is combinational from req and arbiter state in the same cycle N; the request is consumed at the end of N.
  - Dropping req before gnt is legal; the request is not performed.
- Grant: at most one gnt per cycle. Default fixed priority: m0 wins on contention.
- Pipeline, grant in cycle N:
  - N+1: ram_addr/ram_din/ram_we hold the granted command. ram_we=1 only for a write.
  - End of N+1: ram_dout is captured into the owner's rdata for a read.
  - N+2: owner's rvalid=1 for one cycle. No rvalid is generated for writes.
- Throughput: back-to-back grants every cycle, to either port, with no bubbles.
- Idle cycle (no grant): ram_we=0; ram_addr/ram_din hold their previous values.
- rdata holds its last read value until the next read completes for that port. The non-owning port's rdata is unchanged.
- Write in N followed by read of the same address granted in N+1: the read returns the new data. The write commits at the end of N+1 and the read address is presented in N+2.
- Reset asserted mid-operation: in-flight read is discarded, no rvalid follows; ram_we=0 in the next cycle.
- Requests asserted during rst are ignored; the first grant is possible in the cycle after rst deasserts.
- Width rules: no arithmetic; addresses pass through unmodified, no wrap or extension.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-granted pointer (reset 1) updates on every grant.
  - On contention, the port not last granted wins.
  - An uncontested request is granted regardless of the pointer.
- Undefined: strict fixed priority, m0 always wins; the pointer logic is absent.

Decomposition:
- Shared package: ADDR_W/DATA_W constants; port index constants PORT_CPU=0, PORT_LOADER=1; command struct {we, addr, wdata}.
- One natural sub-module, ram_arbiter_pick: combinational 2-way grant selection. It is fixed-priority, or round-robin under the macro.
- Pipeline registers and read-owner tag stay in the top.

Test Plan:
- Single read: m0 reads addr 0x00 (RAM holds 0xC64) -> m0_gnt in N; ram_addr=0x00 in N+1; m0_rvalid=1 and m0_rdata=0xC64 in N+2; m1 outputs unchanged.
- Write then read-back: m1 writes 0x5A5 to addr 0x10, then m1 reads 0x10 in the next cycle -> ram_we=1 for one cycle; read returns 0x5A5 two cycles after its grant.
- Contention, fixed priority: m0 and m1 both hold req for 4 cycles with distinct addresses -> m0 granted in all 4 cycles, m1 starved.
- Contention, RR build (same stimulus as the fixed-priority case) -> grants alternate m0, m1, m0, m1. Each rvalid arrives at grant+2 on the correct port with the correct data.
- Reset mid-read: grant m0 read in N, assert rst in N+1 -> no m0_rvalid in N+2; all outputs at reset values. First grant after release is honoured normally.
- Back-to-back mixed: m0 read 0x01, m1 read 0x02, m0 write 0x03 in consecutive cycles -> m0_rvalid=1 with m0_rdata=0x082 at the first grant+2, m1_rvalid=1 with m1_rdata=0xF00 at the second grant+2. No rvalid for the write; no idle cycles on ram_addr.
